// File: rtl/fm_add_xfer_arb_if.sv
// fm_add_xfer_arb_if: requester descriptors, grant/done handshakes and engine control for the transfer arbiter.
interface fm_add_xfer_arb_if #(
  parameter int APP_ADDR_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 6
);
  logic init_calib_complete;
  logic req_0, req_1, rd_wr_0, rd_wr_1;
  logic [APP_ADDR_WIDTH-1:0] ddr_addr_0, ddr_addr_1;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_0, bram_addr_1;
  logic gnt_0, gnt_1, done_0, done_1, err, busy;
  logic module_en, rd_wr, module_done;
  logic [APP_ADDR_WIDTH-1:0] ddr_begin_addr;
  logic [BRAM_ADDR_WIDTH-1:0] bram_begin_addr;
  modport master (
    output init_calib_complete, req_0, req_1, rd_wr_0, rd_wr_1,
           ddr_addr_0, ddr_addr_1, bram_addr_0, bram_addr_1, module_done,
    input  gnt_0, gnt_1, done_0, done_1, err, busy,
           module_en, rd_wr, ddr_begin_addr, bram_begin_addr
  );
  modport slave (
    input  init_calib_complete, req_0, req_1, rd_wr_0, rd_wr_1,
           ddr_addr_0, ddr_addr_1, bram_addr_0, bram_addr_1, module_done,
    output gnt_0, gnt_1, done_0, done_1, err, busy,
           module_en, rd_wr, ddr_begin_addr, bram_begin_addr
  );
endinterface

// File: rtl/fm_add_xfer_arb.sv
// fm_add_xfer_arb: round-robin arbiter handing one DDR<->BRAM transfer engine to two requesters.
// Optional BUSY watchdog enabled by defining FM_XFER_WDOG_EN.
module fm_add_xfer_arb #(
  parameter int APP_ADDR_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int WDOG_CYCLES = 4096
) (
  input logic clk,
  input logic rst,
  fm_add_xfer_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic owner, last, sel, abort, timeout, en_q, err_q, rd_wr_q;
  logic [APP_ADDR_WIDTH-1:0] ddr_q;
  logic [BRAM_ADDR_WIDTH-1:0] bram_q;
`ifdef FM_XFER_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wdog;
  // held at zero through the module_en cycle, so the limit counts from the cycle after BUSY entry
  always_ff @(posedge clk)
    if (rst) wdog <= '0;
    else wdog <= (state == BUSY && !en_q) ? wdog + WW'(1) : '0;
  assign timeout = wdog == WW'(WDOG_CYCLES - 1);
`else
  assign timeout = WDOG_CYCLES < 0;
`endif
  assign sel = (bus.req_0 && bus.req_1) ? !last : bus.req_1;
  always_comb begin
    state_n = state;
    abort = 1'b0;
    case (state)
      IDLE: state_n = (bus.init_calib_complete && (bus.req_0 || bus.req_1)) ? ISSUE : IDLE;
      ISSUE: state_n = BUSY;
      BUSY: begin
        abort = !bus.init_calib_complete || timeout;
        state_n = (abort || bus.module_done) ? RESP : BUSY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      en_q <= 1'b0;
      err_q <= 1'b0;
      rd_wr_q <= 1'b0;
      ddr_q <= '0;
      bram_q <= '0;
    end else begin
      state <= state_n;
      en_q <= state == ISSUE;
      err_q <= abort;
      if (state == IDLE && state_n == ISSUE) begin
        owner <= sel;
        rd_wr_q <= sel ? bus.rd_wr_1 : bus.rd_wr_0;
        ddr_q <= sel ? bus.ddr_addr_1 : bus.ddr_addr_0;
        bram_q <= sel ? bus.bram_addr_1 : bus.bram_addr_0;
      end
      if (state == RESP) last <= owner;
    end
  assign bus.gnt_0 = state == ISSUE && !owner;
  assign bus.gnt_1 = state == ISSUE && owner;
  assign bus.done_0 = state == RESP && !owner;
  assign bus.done_1 = state == RESP && owner;
  assign bus.err = err_q;
  assign bus.busy = state != IDLE;
  assign bus.module_en = en_q;
  assign bus.rd_wr = rd_wr_q;
  assign bus.ddr_begin_addr = ddr_q;
  assign bus.bram_begin_addr = bram_q;
endmodule

// File: tb/tb_fm_add_xfer_arb.sv
// tb_fm_add_xfer_arb: directed stimulus with a cycle-stamped event scoreboard for fm_add_xfer_arb.
module tb_fm_add_xfer_arb;
`ifdef FM_XFER_WDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 4096;
`endif
  typedef struct {
    int kind;
    int id;
    logic [63:0] data;
    int cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_en = -1;
  ev_t exp_q[$];
  fm_add_xfer_arb_if #(.APP_ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(6)) bus();
  fm_add_xfer_arb #(.APP_ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(6), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] pk(logic rd, logic [31:0] ddr, logic [5:0] bram);
    return {25'd0, rd, ddr, bram};
  endfunction
  task automatic push(int kind, int id, logic [63:0] data, int at);
    ev_t e;
    e.kind = kind;
    e.id = id;
    e.data = data;
    e.cyc = at;
    exp_q.push_back(e);
  endtask
  task automatic observe(int kind, int id, logic [63:0] data);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected event: got kind=%0d id=%0d data=%h cyc=%0d, required none", kind, id, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.id != id || e.data != data || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got kind=%0d id=%0d data=%h cyc=%0d, required kind=%0d id=%0d data=%h cyc=%0d",
                 kind, id, data, cyc, e.kind, e.id, e.data, e.cyc);
      end
    end
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, req, cyc);
    end
  endtask
  // kinds: 0 = grant, 1 = module_en with descriptor, 2 = done with err
  always @(negedge clk) begin
    if (bus.gnt_0) observe(0, 0, 64'd0);
    if (bus.gnt_1) observe(0, 1, 64'd0);
    if (bus.module_en) observe(1, 0, pk(bus.rd_wr, bus.ddr_begin_addr, bus.bram_begin_addr));
    if (bus.done_0) observe(2, 0, {63'd0, bus.err});
    if (bus.done_1) observe(2, 1, {63'd0, bus.err});
    if (bus.gnt_0 || bus.gnt_1 || bus.done_0 || bus.done_1)
      chk("onehot", {62'd0, bus.gnt_0 && bus.gnt_1, bus.done_0 && bus.done_1}, 64'd0);
    if (bus.module_en) begin
      if (last_en >= 0) chk("en_spacing_ok", {63'd0, (cyc - last_en) >= 4}, 64'd1);
      last_en = cyc;
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_idle_outputs(string tag);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_en"}, {63'd0, bus.module_en}, 64'd0);
    chk({tag, "_err"}, {63'd0, bus.err}, 64'd0);
    chk({tag, "_gnt_done"}, {60'd0, bus.gnt_0, bus.gnt_1, bus.done_0, bus.done_1}, 64'd0);
    chk({tag, "_desc"}, pk(bus.rd_wr, bus.ddr_begin_addr, bus.bram_begin_addr), 64'd0);
  endtask
  initial begin
    int c;
    bus.init_calib_complete = 1'b0;
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    bus.rd_wr_0 = 1'b0;
    bus.rd_wr_1 = 1'b0;
    bus.ddr_addr_0 = '0;
    bus.ddr_addr_1 = '0;
    bus.bram_addr_0 = '0;
    bus.bram_addr_1 = '0;
    bus.module_done = 1'b0;
    tick(3);
    @(negedge clk);
    chk_idle_outputs("reset");
    tick(1);
    rst = 1'b0;
    bus.init_calib_complete = 1'b1;
    tick(2);
    // single DDR->BRAM transfer, engine finishes 20 cycles after module_en
    c = cyc;
    bus.req_0 = 1'b1;
    bus.rd_wr_0 = 1'b0;
    bus.ddr_addr_0 = 32'h1000;
    bus.bram_addr_0 = 6'd5;
    push(0, 0, 64'd0, c + 1);
    push(1, 0, pk(1'b0, 32'h1000, 6'd5), c + 2);
    push(2, 0, 64'd0, c + 23);
    tick(2);
    bus.req_0 = 1'b0;
    tick(8);
    @(negedge clk);
    chk("busy_mid", {63'd0, bus.busy}, 64'd1);
    tick(12);
    bus.module_done = 1'b1;
    tick(1);
    bus.module_done = 1'b0;
    tick(2);
    // fresh reset, then both requesters continuously with an always-done engine
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    c = cyc;
    bus.rd_wr_0 = 1'b1;
    bus.ddr_addr_0 = 32'h2000;
    bus.bram_addr_0 = 6'd1;
    bus.rd_wr_1 = 1'b0;
    bus.ddr_addr_1 = 32'h3000;
    bus.bram_addr_1 = 6'd2;
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    bus.module_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, k % 2, 64'd0, c + 1 + 4 * k);
      push(1, 0, (k % 2) ? pk(1'b0, 32'h3000, 6'd2) : pk(1'b1, 32'h2000, 6'd1), c + 2 + 4 * k);
      push(2, k % 2, 64'd0, c + 3 + 4 * k);
    end
    tick(16);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    bus.module_done = 1'b0;
    tick(2);
    // request while calibration is low waits, then is granted the cycle after calibration rises
    c = cyc;
    bus.init_calib_complete = 1'b0;
    bus.req_1 = 1'b1;
    bus.rd_wr_1 = 1'b1;
    bus.ddr_addr_1 = 32'h4000;
    bus.bram_addr_1 = 6'd7;
    push(0, 1, 64'd0, c + 6);
    push(1, 0, pk(1'b1, 32'h4000, 6'd7), c + 7);
    push(2, 1, 64'd0, c + 10);
    tick(5);
    bus.init_calib_complete = 1'b1;
    tick(2);
    bus.req_1 = 1'b0;
    tick(2);
    bus.module_done = 1'b1;
    tick(1);
    bus.module_done = 1'b0;
    tick(2);
    // calibration lost mid-BUSY aborts with err
    c = cyc;
    bus.req_0 = 1'b1;
    bus.rd_wr_0 = 1'b0;
    bus.ddr_addr_0 = 32'h5000;
    bus.bram_addr_0 = 6'd9;
    push(0, 0, 64'd0, c + 1);
    push(1, 0, pk(1'b0, 32'h5000, 6'd9), c + 2);
    push(2, 0, 64'd1, c + 7);
    tick(2);
    bus.req_0 = 1'b0;
    tick(4);
    bus.init_calib_complete = 1'b0;
    tick(2);
    @(negedge clk);
    chk("busy_after_abort", {63'd0, bus.busy}, 64'd0);
    tick(1);
    bus.init_calib_complete = 1'b1;
    tick(1);
    // reset mid-BUSY abandons the transfer; dual request afterwards grants 0 first
    c = cyc;
    bus.req_1 = 1'b1;
    bus.rd_wr_1 = 1'b1;
    bus.ddr_addr_1 = 32'h6000;
    bus.bram_addr_1 = 6'd3;
    push(0, 1, 64'd0, c + 1);
    push(1, 0, pk(1'b1, 32'h6000, 6'd3), c + 2);
    tick(2);
    bus.req_1 = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    tick(1);
    rst = 1'b0;
    tick(1);
    c = cyc;
    bus.req_0 = 1'b1;
    bus.rd_wr_0 = 1'b0;
    bus.ddr_addr_0 = 32'h7000;
    bus.bram_addr_0 = 6'd4;
    bus.req_1 = 1'b1;
    bus.rd_wr_1 = 1'b1;
    bus.ddr_addr_1 = 32'h8000;
    bus.bram_addr_1 = 6'd6;
    push(0, 0, 64'd0, c + 1);
    push(1, 0, pk(1'b0, 32'h7000, 6'd4), c + 2);
    push(2, 0, 64'd0, c + 5);
    push(0, 1, 64'd0, c + 7);
    push(1, 0, pk(1'b1, 32'h8000, 6'd6), c + 8);
    push(2, 1, 64'd0, c + 10);
    tick(2);
    bus.req_0 = 1'b0;
    tick(2);
    bus.module_done = 1'b1;
    tick(1);
    bus.module_done = 1'b0;
    tick(3);
    bus.req_1 = 1'b0;
    tick(1);
    bus.module_done = 1'b1;
    tick(1);
    bus.module_done = 1'b0;
    tick(3);
`ifdef FM_XFER_WDOG_EN
    // engine never answers: watchdog aborts 17 cycles after BUSY entry; late module_done is ignored
    c = cyc;
    bus.req_0 = 1'b1;
    bus.rd_wr_0 = 1'b0;
    bus.ddr_addr_0 = 32'hA000;
    bus.bram_addr_0 = 6'd11;
    push(0, 0, 64'd0, c + 1);
    push(1, 0, pk(1'b0, 32'hA000, 6'd11), c + 2);
    push(2, 0, 64'd1, c + 19);
    tick(2);
    bus.req_0 = 1'b0;
    tick(19);
    bus.module_done = 1'b1;
    tick(1);
    bus.module_done = 1'b0;
    tick(3);
    @(negedge clk);
    chk("busy_after_wdog", {63'd0, bus.busy}, 64'd0);
`endif
    tick(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
